store_monitor: RTL and testbench
================================

# store_monitor

Synthesizable end-of-test monitor that sits directly downstream of the processor `top`. It consumes the data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) plus `PC`. It decides pass, fail or timeout from the first store to a designated mailbox address, and latches the verdict for the bench or an FPGA LED/UART stage. It replaces ad-hoc negedge checking in simulation with a cycle-accurate, reusable verdict machine.

## Interface
- `PASS_ADDR`, 32'd128: mailbox address that ends the test.
- `PASS_DATA`, 32'd254: value at `PASS_ADDR` that means pass.
- `TIMEOUT_CYCLES`, 64: RUN cycles allowed before timeout, 1..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `enable`  in  1  arms the monitor; sampled in IDLE only.
- `MemWrite`  in  1  store strobe from `top`.
- `DataAdr`  in  32  store address from `top`.
- `WriteData`  in  32  store data from `top`.
- `PC`  in  32  current PC from `top`.
- `done`  out  1  verdict reached, equal to `pass | fail | timeout`.
- `pass`  out  1  mailbox written with `PASS_DATA`.
- `fail`  out  1  mailbox written with any other value.
- `timeout`  out  1  no mailbox write within `TIMEOUT_CYCLES`.
- `verdict_pc`  out  32  `PC` captured on the verdict edge.
- `store_count`  out  16  stores seen in RUN, saturating.
- `trace_rd_idx`  in  3  trace read index; 0 is the newest entry.
- `trace_addr`  out  32  address of the selected trace entry.
- `trace_data`  out  32  data of the selected trace entry.
- `trace_level`  out  4  valid trace entries, 0..8.

## Operation
- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT.
- Reset puts the FSM in IDLE. All outputs read 0, and the cycle counter, `store_count` and the trace buffer are cleared.
- IDLE → RUN on an edge with `enable`=1. Stores during IDLE are ignored.
- In RUN, each edge with `MemWrite`=1 is a store:
  - `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - `DataAdr`==`PASS_ADDR` and any other data → FAIL.
  - Any other address → stay in RUN.
- Every store sampled in RUN, including the verdict store, increments `store_count`. The count saturates at 16'hFFFF.
- The RUN cycle counter increments every RUN edge. When it reaches `TIMEOUT_CYCLES` without a verdict store, the FSM enters TIMEOUT.
- If a mailbox store arrives on the same edge as the timeout limit, the store decision wins.
- PASS, FAIL and TIMEOUT are sticky; only reset leaves them. `enable` is ignored outside IDLE.
- `verdict_pc` loads `PC` on the edge that enters any terminal state.
- Mailbox comparison is exact 32-bit equality with no address masking.

## Timing
- Every output except `trace_addr` and `trace_data` is registered.
- Verdict latency is one edge: a store sampled at edge N shows `pass` or `fail` high immediately after edge N.
- A counter reaching the limit at edge N shows `timeout` high after edge N.
- `trace_addr` and `trace_data` are combinational reads of registered storage, indexed by `trace_rd_idx`.
- Reset assertion mid-RUN or mid-verdict clears everything asynchronously and does not wait for a clock.
- Reset release is synchronized to `clk`; the first state change can happen no earlier than the second rising edge after release.

## Configuration
- `STORE_MONITOR_TRACE_EN` defined: an 8-entry circular buffer records {`DataAdr`, `WriteData`} for every store sampled in RUN.
  - The buffer overwrites the oldest entry on wrap.
  - `trace_level` saturates at 8.
  - An index at or above `trace_level` reads 0.
- `STORE_MONITOR_TRACE_EN` undefined: the buffer is not built. `trace_addr`, `trace_data` and `trace_level` are tied to 0; the ports remain.

## Structure
- Shared package `store_monitor_pkg` holds:
  - the state enum `mon_state_t`;
  - `TRACE_DEPTH`=8;
  - the default `PASS_ADDR` and `PASS_DATA` constants, shared with the testbench.
- One sub-module, `store_trace_buf`, contains the circular buffer, write pointer and level counter, plus the read mux. It is instantiated only under `STORE_MONITOR_TRACE_EN`.

## Test plan
- Mailbox pass: reset low for 1 cycle, then `enable`=1. Stores to 100 and 104, then a store of 254 to 128 at RUN cycle 10 → `pass`=1 and `done`=1 the next cycle, `store_count`=3, `verdict_pc` equals PC at that edge.
- Mailbox fail: store of 255 to 128 → `fail`=1, `pass`=0. A later store of 254 to 128 leaves `fail` set and `store_count` unchanged.
- Timeout: `TIMEOUT_CYCLES`=16 with no mailbox store → `timeout`=1 after the 16th RUN edge. A mailbox store on exactly the 16th edge → `pass`=1, `timeout`=0.
- Mid-run reset: drop reset after 5 stores → all outputs 0 with no clock edge needed. The FSM returns to IDLE and ignores stores until `enable` is asserted again.
- Trace wrap (macro on): 10 stores with addresses 0,4,…,36 → `trace_level`=8, index 0 reads 36, index 7 reads 8. With the macro off, the trace outputs stay 0.

Source files
------------

// File: rtl/store_monitor_pkg.sv
// Shared types and constants for the store_monitor end-of-test verdict block.
package store_monitor_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned TRACE_DEPTH = 8;
  localparam int unsigned TRACE_IDX_W = 3;
  localparam int unsigned TRACE_LVL_W = 4;

  localparam logic [WORD_W-1:0] DEFAULT_PASS_ADDR      = 32'd128;
  localparam logic [WORD_W-1:0] DEFAULT_PASS_DATA      = 32'd254;
  localparam int unsigned       DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    MON_IDLE,
    MON_RUN,
    MON_PASS,
    MON_FAIL,
    MON_TIMEOUT
  } mon_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/store_trace_buf.sv
// Circular store trace: newest entry at read index 0, level saturates at depth.
module store_trace_buf
  import store_monitor_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   wrEn,
  input  trace_entry_t           wrEntry,
  input  logic [TRACE_IDX_W-1:0] rdIdx,
  output trace_entry_t           rdEntry,
  output logic [TRACE_LVL_W-1:0] level
);

  trace_entry_t           mem [TRACE_DEPTH];
  logic [TRACE_IDX_W-1:0] wrPtr;
  logic [TRACE_IDX_W-1:0] rdPtr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem   <= '{default: '0};
      wrPtr <= '0;
      level <= '0;
    end else if (wrEn) begin
      mem[wrPtr] <= wrEntry;
      wrPtr      <= wrPtr + TRACE_IDX_W'(1);
      if (level != TRACE_LVL_W'(TRACE_DEPTH)) level <= level + TRACE_LVL_W'(1);
    end
  end

  // Walk backwards from the last written slot; out-of-range reads return zero.
  assign rdPtr = wrPtr - TRACE_IDX_W'(1) - rdIdx;

  always_comb begin
    rdEntry = '0;
    if ({1'b0, rdIdx} < level) rdEntry = mem[rdPtr];
  end

endmodule

// File: rtl/store_monitor.sv
// End-of-test monitor: first mailbox store decides pass/fail, else timeout.
// Optional store trace buffer enabled by defining STORE_MONITOR_TRACE_EN.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [WORD_W-1:0] PASS_ADDR      = DEFAULT_PASS_ADDR,
  parameter logic [WORD_W-1:0] PASS_DATA      = DEFAULT_PASS_DATA,
  parameter int unsigned       TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   MemWrite,
  input  logic [WORD_W-1:0]      DataAdr,
  input  logic [WORD_W-1:0]      WriteData,
  input  logic [WORD_W-1:0]      PC,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic [WORD_W-1:0]      verdict_pc,
  output logic [COUNT_W-1:0]     store_count,
  input  logic [TRACE_IDX_W-1:0] trace_rd_idx,
  output logic [WORD_W-1:0]      trace_addr,
  output logic [WORD_W-1:0]      trace_data,
  output logic [TRACE_LVL_W-1:0] trace_level
);

  logic [1:0]         rstSync;
  logic               rstN;
  mon_state_t         state;
  logic [COUNT_W-1:0] cycleCnt;
  logic               isStore;
  logic               isMailbox;
  logic               limitHit;

  // Assert asynchronously, release two edges after the external reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rstSync <= 2'b00;
    else        rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  assign isStore   = (state == MON_RUN) && MemWrite;
  assign isMailbox = isStore && (DataAdr == PASS_ADDR);
  assign limitHit  = (cycleCnt + COUNT_W'(1)) == COUNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= MON_IDLE;
      cycleCnt    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      verdict_pc  <= '0;
      store_count <= '0;
    end else begin
      case (state)
        MON_IDLE: begin
          if (enable) begin
            state    <= MON_RUN;
            cycleCnt <= '0;
          end
        end
        MON_RUN: begin
          cycleCnt <= cycleCnt + COUNT_W'(1);
          // A mailbox store takes priority over the timeout limit on the same edge.
          if (isMailbox) begin
            done       <= 1'b1;
            verdict_pc <= PC;
            if (WriteData == PASS_DATA) begin
              state <= MON_PASS;
              pass  <= 1'b1;
            end else begin
              state <= MON_FAIL;
              fail  <= 1'b1;
            end
          end else if (limitHit) begin
            state      <= MON_TIMEOUT;
            done       <= 1'b1;
            timeout    <= 1'b1;
            verdict_pc <= PC;
          end
        end
        default: ;
      endcase
      if (isStore && (store_count != '1)) store_count <= store_count + COUNT_W'(1);
    end
  end

`ifdef STORE_MONITOR_TRACE_EN
  trace_entry_t wrEntry;
  trace_entry_t rdEntry;

  assign wrEntry = '{addr: DataAdr, data: WriteData};

  store_trace_buf uTrace (
    .clk     (clk),
    .rstN    (rstN),
    .wrEn    (isStore),
    .wrEntry (wrEntry),
    .rdIdx   (trace_rd_idx),
    .rdEntry (rdEntry),
    .level   (trace_level)
  );

  assign trace_addr = rdEntry.addr;
  assign trace_data = rdEntry.data;
`else
  logic unusedTraceIdx;
  assign unusedTraceIdx = ^trace_rd_idx;
  assign trace_addr     = '0;
  assign trace_data     = '0;
  assign trace_level    = '0;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Directed self-checking bench for store_monitor (timeout limit set to 16).
module tb_store_monitor;
  import store_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] PC;
  logic        done, pass, fail, timeout;
  logic [31:0] verdict_pc;
  logic [15:0] store_count;
  logic [2:0]  trace_rd_idx;
  logic [31:0] trace_addr, trace_data;
  logic [3:0]  trace_level;

  int passCnt  = 0;
  int totalCnt = 0;

  store_monitor #(
    .PASS_ADDR      (DEFAULT_PASS_ADDR),
    .PASS_DATA      (DEFAULT_PASS_DATA),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .MemWrite     (MemWrite),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .PC           (PC),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .verdict_pc   (verdict_pc),
    .store_count  (store_count),
    .trace_rd_idx (trace_rd_idx),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data),
    .trace_level  (trace_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] pc;
    logic        ePass;
    logic        eFail;
    logic        eTo;
    logic [15:0] eCnt;
    logic [31:0] eVpc;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noStore();
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic putStore(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
  endtask

  task automatic checkVerdict(input string tag, input logic p, input logic f, input logic t,
                              input logic [15:0] cnt);
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".fail"}, 32'(fail), 32'(f));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
    check({tag, ".done"}, 32'(done), 32'(p | f | t));
    check({tag, ".count"}, 32'(store_count), 32'(cnt));
  endtask

  // Reset for one cycle, wait out the release synchronizer, then arm for one edge.
  task automatic startRun();
    enable = 1'b0;
    noStore();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    trace_rd_idx = '0;
    PC           = '0;
    noStore();
    #2;
    checkVerdict("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset.vpc", verdict_pc, 32'd0);
    check("reset.level", 32'(trace_level), 32'd0);

    // Mailbox pass at RUN edge 10, then sticky verdict.
    tbl[0] = '{1'b1, 32'd100, 32'd11,  32'h100, 1'b0, 1'b0, 1'b0, 16'd1, 32'h0};
    tbl[1] = '{1'b1, 32'd104, 32'd22,  32'h104, 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
    for (int i = 2; i < 9; i++)
      tbl[i] = '{1'b0, 32'd0, 32'd0, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
    tbl[9]  = '{1'b1, 32'd128, 32'd254, 32'h124, 1'b1, 1'b0, 1'b0, 16'd3, 32'h124};
    tbl[10] = '{1'b1, 32'd128, 32'd255, 32'h128, 1'b1, 1'b0, 1'b0, 16'd3, 32'h124};
    tbl[11] = '{1'b0, 32'd0,   32'd0,   32'h12c, 1'b1, 1'b0, 1'b0, 16'd3, 32'h124};

    startRun();
    for (int i = 0; i < 12; i++) begin
      MemWrite  = tbl[i].we;
      DataAdr   = tbl[i].adr;
      WriteData = tbl[i].dat;
      PC        = tbl[i].pc;
      tick();
      checkVerdict($sformatf("tbl%0d", i), tbl[i].ePass, tbl[i].eFail, tbl[i].eTo, tbl[i].eCnt);
      check($sformatf("tbl%0d.vpc", i), verdict_pc, tbl[i].eVpc);
    end

    // Mailbox fail, later good store ignored.
    startRun();
    PC = 32'h200;
    putStore(32'd128, 32'd255);
    tick();
    checkVerdict("fail", 1'b0, 1'b1, 1'b0, 16'd1);
    check("fail.vpc", verdict_pc, 32'h200);
    PC = 32'h204;
    putStore(32'd128, 32'd254);
    tick();
    checkVerdict("failSticky", 1'b0, 1'b1, 1'b0, 16'd1);
    check("failSticky.vpc", verdict_pc, 32'h200);

    // Timeout on the 16th RUN edge.
    startRun();
    noStore();
    for (int i = 0; i < 15; i++) begin
      PC = 32'h300 + 32'(4 * i);
      tick();
    end
    checkVerdict("to15", 1'b0, 1'b0, 1'b0, 16'd0);
    PC = 32'h3f0;
    tick();
    checkVerdict("to16", 1'b0, 1'b0, 1'b1, 16'd0);
    check("to16.vpc", verdict_pc, 32'h3f0);

    // Mailbox store on the limit edge wins over timeout.
    startRun();
    noStore();
    repeat (15) tick();
    PC = 32'h4a0;
    putStore(32'd128, 32'd254);
    tick();
    checkVerdict("limitPass", 1'b1, 1'b0, 1'b0, 16'd1);
    check("limitPass.vpc", verdict_pc, 32'h4a0);
    noStore();
    tick();
    checkVerdict("limitPassSticky", 1'b1, 1'b0, 1'b0, 16'd1);

    // Asynchronous reset mid-run, then stores in IDLE are ignored.
    startRun();
    for (int i = 0; i < 5; i++) begin
      putStore(32'd200 + 32'(4 * i), 32'd7);
      tick();
    end
    check("mid.count5", 32'(store_count), 32'd5);
    #1;
    reset = 1'b0;
    #1;
    checkVerdict("midAsync", 1'b0, 1'b0, 1'b0, 16'd0);
    check("midAsync.vpc", verdict_pc, 32'd0);
    check("midAsync.level", 32'(trace_level), 32'd0);
    tick();
    reset = 1'b1;
    putStore(32'd128, 32'd254);
    repeat (5) tick();
    checkVerdict("idleIgnore", 1'b0, 1'b0, 1'b0, 16'd0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checkVerdict("armEdge", 1'b0, 1'b0, 1'b0, 16'd0);
    PC = 32'h5c0;
    tick();
    checkVerdict("rearmPass", 1'b1, 1'b0, 1'b0, 16'd1);
    check("rearmPass.vpc", verdict_pc, 32'h5c0);

    // Trace fill and wrap with addresses 0,4,...,36.
    startRun();
    for (int i = 0; i < 3; i++) begin
      putStore(32'(4 * i), 32'd1000 + 32'(4 * i));
      tick();
    end
    noStore();
`ifdef STORE_MONITOR_TRACE_EN
    check("trace.level3", 32'(trace_level), 32'd3);
    trace_rd_idx = 3'd2;
    #1;
    check("trace.idx2.data", trace_data, 32'd1000);
    trace_rd_idx = 3'd3;
    #1;
    check("trace.idx3.addr", trace_addr, 32'd0);
    check("trace.idx3.data", trace_data, 32'd0);
`endif
    for (int i = 3; i < 10; i++) begin
      putStore(32'(4 * i), 32'd1000 + 32'(4 * i));
      tick();
    end
    noStore();
    check("trace.count", 32'(store_count), 32'd10);
`ifdef STORE_MONITOR_TRACE_EN
    check("trace.level8", 32'(trace_level), 32'd8);
    trace_rd_idx = 3'd0;
    #1;
    check("trace.idx0.addr", trace_addr, 32'd36);
    check("trace.idx0.data", trace_data, 32'd1036);
    trace_rd_idx = 3'd7;
    #1;
    check("trace.idx7.addr", trace_addr, 32'd8);
    check("trace.idx7.data", trace_data, 32'd1008);
`else
    check("trace.level.off", 32'(trace_level), 32'd0);
    trace_rd_idx = 3'd0;
    #1;
    check("trace.addr.off", trace_addr, 32'd0);
    check("trace.data.off", trace_data, 32'd0);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
